// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: boot PC, nop encoding,
// fetch FSM states, fault causes and read-response codes.
package inst_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IDLE = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } fetch_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_BUSERR   = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // RV32 without compressed instructions requires word-aligned fetches.
  function automatic logic is_misaligned(input logic [1:0] pc_low);
    return pc_low != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one single-beat read per committed instruction,
// with misaligned-PC and bus-error fault reporting and a fetch counter.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(inst_fetch_unit_pkg::RESET_PC)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_next_pc,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [31:0]       i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_fault,
  output logic [1:0]        o_fault_cause,
  output logic              o_valid,
  output logic [31:0]       o_fetch_cnt
);
  import inst_fetch_unit_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic [31:0]       inst_q;
  logic              fault_q;
  logic [1:0]        cause_q;
  logic [31:0]       cnt_q;

  logic [ADDR_W-1:0] check_pc;
  logic              start_check;
  logic              misalign_done;
  logic              bus_done;
  logic              bus_err;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    check_pc    = pc_q;
    start_check = 1'b0;
    bus_done    = 1'b0;
    unique case (state_q)
      ST_BOOT: start_check = 1'b1;
      ST_IDLE: begin
        if (i_valid) begin
          check_pc    = i_next_pc;
          start_check = 1'b1;
        end
      end
      ST_REQ:  if (i_arready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_rvalid) begin
          bus_done = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_BOOT;
    endcase
    // Alignment check shares the accept cycle; a bad PC never reaches the bus.
    misalign_done = start_check && is_misaligned(check_pc[1:0]);
    if (start_check) state_d = misalign_done ? ST_DONE : ST_REQ;
  end

  assign bus_err = (i_rresp != RESP_OKAY);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= ST_BOOT;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q     <= RESET_PC;
      out_pc_q <= RESET_PC;
      inst_q   <= NOP_INST;
      fault_q  <= 1'b0;
      cause_q  <= FC_NONE;
      cnt_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && i_valid) pc_q <= i_next_pc;
      if (misalign_done) begin
        inst_q   <= NOP_INST;
        fault_q  <= 1'b1;
        cause_q  <= FC_MISALIGN;
        out_pc_q <= check_pc;
        cnt_q    <= cnt_q + 32'd1;
      end else if (bus_done) begin
        inst_q   <= bus_err ? NOP_INST : i_rdata;
        fault_q  <= bus_err;
        cause_q  <= bus_err ? FC_BUSERR : FC_NONE;
        out_pc_q <= pc_q;
        cnt_q    <= cnt_q + 32'd1;
      end
    end
  end

  // Reset forces every output to its idle value in the cycle it is asserted.
  assign o_araddr      = i_reset ? RESET_PC : pc_q;
  assign o_arvalid     = !i_reset && (state_q == ST_REQ);
  assign o_rready      = !i_reset && (state_q == ST_WAIT);
  assign o_valid       = !i_reset && (state_q == ST_DONE);
  assign o_inst        = i_reset ? NOP_INST : inst_q;
  assign o_pc          = i_reset ? RESET_PC : out_pc_q;
  assign o_fault       = !i_reset && fault_q;
  assign o_fault_cause = i_reset ? FC_NONE : cause_q;
  assign o_fetch_cnt   = i_reset ? 32'd0 : cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a bus-slave driver with random
// handshake delays and a transaction-level model of the expected results.
module tb_inst_fetch_unit;

  localparam logic [31:0] BOOT_PC = 32'h8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_next_pc;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        o_rready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_fault;
  logic [1:0]  o_fault_cause;
  logic        o_valid;
  logic [31:0] o_fetch_cnt;

  inst_fetch_unit dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_next_pc     (i_next_pc),
    .o_araddr      (o_araddr),
    .o_arvalid     (o_arvalid),
    .i_arready     (i_arready),
    .i_rdata       (i_rdata),
    .i_rresp       (i_rresp),
    .i_rvalid      (i_rvalid),
    .o_rready      (o_rready),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_fault       (o_fault),
    .o_fault_cause (o_fault_cause),
    .o_valid       (o_valid),
    .o_fetch_cnt   (o_fetch_cnt)
  );

  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the architecturally visible result of the last completed fetch.
  logic [31:0] exp_inst;
  logic [31:0] exp_pc;
  logic        exp_fault;
  logic [1:0]  exp_cause;
  logic [31:0] exp_cnt;
  bit          pc_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic model_reset();
    exp_inst  = NOP;
    exp_fault = 1'b0;
    exp_cause = 2'b00;
    exp_cnt   = 32'd0;
    pc_known  = 1'b0;
  endtask

  task automatic model_complete(input logic [31:0] pc, input logic [31:0] data,
                                input logic [1:0] resp);
    exp_cnt  = exp_cnt + 32'd1;
    exp_pc   = pc;
    pc_known = 1'b1;
    if (pc[1:0] != 2'b00) begin
      exp_fault = 1'b1;
      exp_cause = 2'b01;
      exp_inst  = NOP;
    end else if (resp != 2'b00) begin
      exp_fault = 1'b1;
      exp_cause = 2'b10;
      exp_inst  = NOP;
    end else begin
      exp_fault = 1'b0;
      exp_cause = 2'b00;
      exp_inst  = data;
    end
  endtask

  task automatic check_held(input string where);
    check({where, ".inst"},  o_inst, exp_inst);
    check({where, ".fault"}, 32'(o_fault), 32'(exp_fault));
    check({where, ".cause"}, 32'(o_fault_cause), 32'(exp_cause));
    check({where, ".cnt"},   o_fetch_cnt, exp_cnt);
    if (pc_known) check({where, ".pc"}, o_pc, exp_pc);
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, ".arvalid"}, 32'(o_arvalid), 32'd0);
    check({where, ".rready"},  32'(o_rready), 32'd0);
    check({where, ".valid"},   32'(o_valid), 32'd0);
    check({where, ".inst"},    o_inst, NOP);
    check({where, ".fault"},   32'(o_fault), 32'd0);
    check({where, ".cause"},   32'(o_fault_cause), 32'd0);
    check({where, ".cnt"},     o_fetch_cnt, 32'd0);
  endtask

  // Starts with the DUT presenting a read request; drives both handshakes
  // after the given stall counts and checks the single completion pulse.
  task automatic bus_phase(input logic [31:0] pc, input int ar_d, input int r_d,
                           input logic [31:0] data, input logic [1:0] resp, input bit glitch);
    for (int k = 0; k <= ar_d; k++) begin
      check("req.arvalid", 32'(o_arvalid), 32'd1);
      check("req.araddr",  o_araddr, pc);
      check("req.rready",  32'(o_rready), 32'd0);
      check("req.valid",   32'(o_valid), 32'd0);
      check_held("req");
      i_arready = (k == ar_d);
      i_valid   = glitch && ($urandom_range(0, 1) == 1);
      i_next_pc = $urandom;
      i_rvalid  = glitch && ($urandom_range(0, 1) == 1);
      i_rdata   = $urandom;
      i_rresp   = 2'($urandom);
      tick();
    end
    i_arready = 1'b0;
    for (int k = 0; k <= r_d; k++) begin
      check("wait.rready",  32'(o_rready), 32'd1);
      check("wait.arvalid", 32'(o_arvalid), 32'd0);
      check("wait.valid",   32'(o_valid), 32'd0);
      check_held("wait");
      i_rvalid  = (k == r_d);
      i_rdata   = (k == r_d) ? data : $urandom;
      i_rresp   = (k == r_d) ? resp : 2'($urandom);
      i_valid   = glitch && ($urandom_range(0, 1) == 1);
      i_next_pc = $urandom;
      tick();
    end
    i_rvalid = 1'b0;
    i_valid  = 1'b0;
    model_complete(pc, data, resp);
    check("done.valid",   32'(o_valid), 32'd1);
    check("done.arvalid", 32'(o_arvalid), 32'd0);
    check("done.rready",  32'(o_rready), 32'd0);
    check_held("done");
    tick();
    check("after.valid", 32'(o_valid), 32'd0);
    check_held("after");
  endtask

  task automatic fetch(input logic [31:0] pc, input int ar_d, input int r_d,
                       input logic [31:0] data, input logic [1:0] resp, input bit glitch);
    i_valid   = 1'b1;
    i_next_pc = pc;
    tick();
    i_valid = 1'b0;
    if (pc[1:0] != 2'b00) begin
      model_complete(pc, data, resp);
      check("mis.valid",   32'(o_valid), 32'd1);
      check("mis.arvalid", 32'(o_arvalid), 32'd0);
      check_held("mis");
      tick();
      check("mis_after.valid",   32'(o_valid), 32'd0);
      check("mis_after.arvalid", 32'(o_arvalid), 32'd0);
    end else begin
      bus_phase(pc, ar_d, r_d, data, resp, glitch);
    end
  endtask

  // Idle cycles with stray read-data beats that must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      check("idle.valid",   32'(o_valid), 32'd0);
      check("idle.arvalid", 32'(o_arvalid), 32'd0);
      check("idle.rready",  32'(o_rready), 32'd0);
      check_held("idle");
      i_rvalid = ($urandom_range(0, 1) == 1);
      i_rdata  = $urandom;
      tick();
      i_rvalid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] pc;
    logic [1:0]  resp;
    i_reset   = 1'b1;
    i_valid   = 1'b0;
    i_next_pc = '0;
    i_arready = 1'b0;
    i_rdata   = '0;
    i_rresp   = 2'b00;
    i_rvalid  = 1'b0;
    model_reset();

    @(negedge i_clock);
    check_reset_outputs("reset");
    tick();
    i_reset = 1'b0;
    check("boot.arvalid", 32'(o_arvalid), 32'd0);
    tick();
    bus_phase(BOOT_PC, 0, 0, 32'h0010_0093, 2'b00, 1'b0);

    fetch(32'h8000_0004, 3, 2, 32'h0020_0113, 2'b00, 1'b0);
    fetch(32'h8000_0006, 0, 0, 32'h1234_5678, 2'b00, 1'b0);
    fetch(32'h8000_0008, 1, 1, 32'hDEAD_BEEF, 2'b10, 1'b0);
    fetch(32'h8000_000C, 2, 2, 32'h0030_0193, 2'b00, 1'b1);

    for (int t = 0; t < 40; t++) begin
      pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      pc[31:30] = 2'($urandom);
      if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0:       resp = 2'b10;
        1:       resp = 2'b11;
        default: resp = 2'b00;
      endcase
      idle($urandom_range(0, 2));
      fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, resp,
            ($urandom_range(0, 1) == 1));
    end

    // Reset while a read is outstanding; the beat arriving under reset is dropped.
    i_valid   = 1'b1;
    i_next_pc = 32'h8000_0040;
    tick();
    i_valid   = 1'b0;
    i_arready = 1'b1;
    tick();
    i_arready = 1'b0;
    check("rst_wait.rready", 32'(o_rready), 32'd1);
    i_reset  = 1'b1;
    i_rvalid = 1'b1;
    i_rdata  = 32'hCAFE_F00D;
    i_rresp  = 2'b00;
    #1;
    check_reset_outputs("rst_same_cycle");
    tick();
    check_reset_outputs("rst_held");
    i_reset  = 1'b0;
    i_rvalid = 1'b0;
    model_reset();
    check("reboot.arvalid", 32'(o_arvalid), 32'd0);
    check("reboot.valid",   32'(o_valid), 32'd0);
    tick();
    bus_phase(BOOT_PC, 1, 0, 32'h0040_0213, 2'b00, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
